// File: rtl/pipe_pkg.sv
// Shared constants for FIR inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned FIR_DW         = 26;
  localparam int unsigned PIPE_DEPTH_DEF = 4;

  // Width of a counter that must hold values 0..depth.
  function automatic int unsigned occw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data slice of the elastic register chain.
module pipe_stage #(
  parameter int unsigned WIDTH    = 26,
  parameter bit          RST_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v <= 1'b0;
      if (RST_DATA) d <= '0;
    end else if (adv) begin
      v <= src_valid;
      // Data only toggles when a real word arrives.
      if (src_valid) d <= src_data;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready, bubble collapsing and flush.
// Optional occupancy counter enabled by defining PIPE_OCC_CNT_EN.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = FIR_DW,
  parameter int unsigned DEPTH    = PIPE_DEPTH_DEF,
  parameter bit          RST_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_CNT_EN
  ,
  output logic [occw(DEPTH)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_xfer;

  // A stage may advance if the one after it advances or it is itself empty.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~v[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] | ~v[i];
    end
  end

  assign in_ready  = adv[0] & ~rst & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = in_xfer;
      assign src_data  = in_data;
    end else begin : g_link
      assign src_valid = v[i-1];
      assign src_data  = d[i-1];
    end

    pipe_stage #(
      .WIDTH    (WIDTH),
      .RST_DATA (RST_DATA)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .adv       (adv[i]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .v         (v[i]),
      .d         (d[i])
    );
  end

`ifdef PIPE_OCC_CNT_EN
  localparam int unsigned OCCW = occw(DEPTH);

  logic            out_xfer;
  logic [OCCW-1:0] occ_q, occ_d;

  assign out_xfer = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OCCW'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - OCCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) occ_q <= '0;
    else              occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed table plus randomised queue-model checks for pipe_reg_chain (DEPTH 4, 1, 7).
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=4, RST_DATA=1
  logic        a_flush = 0, a_iv = 0, a_ordy = 0, a_ir, a_ov;
  logic [25:0] a_id = '0, a_od;
  // DEPTH=1, RST_DATA=1
  logic        b_flush = 0, b_iv = 0, b_ordy = 0, b_ir, b_ov;
  logic [25:0] b_id = '0, b_od;
  // DEPTH=7, RST_DATA=0
  logic        c_flush = 0, c_iv = 0, c_ordy = 0, c_ir, c_ov;
  logic [25:0] c_id = '0, c_od;
`ifdef PIPE_OCC_CNT_EN
  logic [2:0]  a_occ;
  logic [0:0]  b_occ;
  logic [2:0]  c_occ;
`endif

  pipe_reg_chain #(.WIDTH(26), .DEPTH(4), .RST_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od)
`ifdef PIPE_OCC_CNT_EN
    , .occupancy(a_occ)
`endif
  );

  pipe_reg_chain #(.WIDTH(26), .DEPTH(1), .RST_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od)
`ifdef PIPE_OCC_CNT_EN
    , .occupancy(b_occ)
`endif
  );

  pipe_reg_chain #(.WIDTH(26), .DEPTH(7), .RST_DATA(1'b0)) dut7 (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_od)
`ifdef PIPE_OCC_CNT_EN
    , .occupancy(c_occ)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [25:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        cd;
    logic [25:0] e_od;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fl, input logic iv, input logic [25:0] id, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic cd, input logic [25:0] e_od,
                     input logic [2:0] e_occ);
    vec_t r;
    r.fl = fl; r.iv = iv; r.id = id; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.cd = cd; r.e_od = e_od; r.e_occ = e_occ;
    tbl.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [25:0] qb[$];
  logic [25:0] qc[$];
  logic        b_acc, c_acc;
  int          thr;

  initial begin
    // Streaming 1..10, out_ready=1
    for (int k = 1; k <= 4; k++) add(0, 1, 26'(k), 1, 1, 0, 0, 0, 3'(k - 1));
    for (int k = 5; k <= 10; k++) add(0, 1, 26'(k), 1, 1, 1, 1, 26'(k - 4), 4);
    add(0, 0, 0, 1, 1, 1, 1, 7, 4);
    add(0, 0, 0, 1, 1, 1, 1, 8, 3);
    add(0, 0, 0, 1, 1, 1, 1, 9, 2);
    add(0, 0, 0, 1, 1, 1, 1, 10, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Fill under backpressure, then release
    add(0, 1, 26'h3FFFFFF, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 2, 0, 1, 0, 0, 0, 2);
    add(0, 1, 3, 0, 1, 0, 0, 0, 3);
    add(0, 1, 4, 0, 0, 1, 1, 26'h3FFFFFF, 4);
    add(0, 1, 4, 1, 1, 1, 1, 26'h3FFFFFF, 4);
    add(0, 0, 0, 1, 1, 1, 1, 1, 4);
    add(0, 0, 0, 1, 1, 1, 1, 2, 3);
    add(0, 0, 0, 1, 1, 1, 1, 3, 2);
    add(0, 0, 0, 1, 1, 1, 1, 4, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Bubble collapse: A, two idle cycles, B, stalled output
    add(0, 1, 26'hA, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 26'hB, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 26'hA, 2);
    add(0, 0, 0, 0, 1, 1, 1, 26'hA, 2);
    add(0, 0, 0, 0, 1, 1, 1, 26'hA, 2);
    add(0, 0, 0, 0, 1, 1, 1, 26'hA, 2);
    add(0, 0, 0, 1, 1, 1, 1, 26'hA, 2);
    add(0, 0, 0, 1, 1, 1, 1, 26'hB, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Flush with three words in flight and a word offered
    add(0, 1, 26'h11, 0, 1, 0, 0, 0, 0);
    add(0, 1, 26'h22, 0, 1, 0, 0, 0, 1);
    add(0, 1, 26'h33, 0, 1, 0, 0, 0, 2);
    add(1, 1, 26'h44, 0, 0, 0, 0, 0, 3);
    add(0, 1, 26'h55, 1, 1, 0, 1, 0, 0);
    add(0, 1, 26'h66, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 2);
    add(0, 0, 0, 1, 1, 0, 0, 0, 2);
    add(0, 0, 0, 1, 1, 1, 1, 26'h55, 2);
    add(0, 0, 0, 1, 1, 1, 1, 26'h66, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Flush in the same cycle as an output transfer
    add(0, 1, 26'h77, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 1, 26'h77, 1);
    add(0, 0, 0, 1, 1, 0, 1, 0, 0);

    // Reset held for two cycles
    @(negedge clk);
    rst = 1; a_iv = 1; a_id = 26'h5; a_ordy = 0;
    #1 chk("rst_in_ready_0", 32'(a_ir), 0);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(a_ov), 0);
    chk("rst_out_data", 32'(a_od), 0);
    chk("rst_in_ready_1", 32'(a_ir), 0);
    @(negedge clk);
    rst = 0; a_iv = 0;
    #1;
    chk("post_rst_in_ready", 32'(a_ir), 1);
    chk("post_rst_out_valid", 32'(a_ov), 0);
`ifdef PIPE_OCC_CNT_EN
    chk("post_rst_occ", 32'(a_occ), 0);
`endif

    foreach (tbl[k]) begin
      @(negedge clk);
      a_flush = tbl[k].fl; a_iv = tbl[k].iv; a_id = tbl[k].id; a_ordy = tbl[k].ordy;
      #1;
      chk($sformatf("row%0d_in_ready", k), 32'(a_ir), 32'(tbl[k].e_ir));
      chk($sformatf("row%0d_out_valid", k), 32'(a_ov), 32'(tbl[k].e_ov));
      if (tbl[k].cd) chk($sformatf("row%0d_out_data", k), 32'(a_od), 32'(tbl[k].e_od));
`ifdef PIPE_OCC_CNT_EN
      chk($sformatf("row%0d_occ", k), 32'(a_occ), 32'(tbl[k].e_occ));
`endif
    end
    @(negedge clk);
    a_flush = 0; a_iv = 0;

    // Random traffic on DEPTH=1 and DEPTH=7 against reference queues
    b_acc = 0; c_acc = 0;
    for (int cyc = 0; cyc < 10050; cyc++) begin
      @(negedge clk);
      thr = (cyc / 500) % 3;
      if (cyc >= 10000) begin
        b_iv = 0; c_iv = 0; b_flush = 0; c_flush = 0; b_ordy = 1; c_ordy = 1;
      end else begin
        if (!(b_iv && !b_acc)) begin
          b_iv = ($urandom_range(0, 3) != 0);
          b_id = 26'($urandom);
        end
        if (!(c_iv && !c_acc)) begin
          c_iv = ($urandom_range(0, 3) != 0);
          c_id = 26'($urandom);
        end
        b_ordy = ($urandom_range(0, 2) >= thr);
        c_ordy = ($urandom_range(0, 2) >= thr);
        b_flush = ($urandom_range(0, 99) == 0);
        c_flush = ($urandom_range(0, 99) == 0);
      end
      #1;
`ifdef PIPE_OCC_CNT_EN
      chk("b_occ", 32'(b_occ), 32'(qb.size()));
      chk("c_occ", 32'(c_occ), 32'(qc.size()));
`endif
      chk("b_in_ready", 32'(b_ir), 32'(!b_flush && (b_ordy || qb.size() < 1)));
      chk("c_in_ready", 32'(c_ir), 32'(!c_flush && (c_ordy || qc.size() < 7)));
      chk("b_out_valid", 32'(b_ov), 32'(qb.size() != 0));
      if (qc.size() == 0) chk("c_out_valid_empty", 32'(c_ov), 0);
      if (qb.size() != 0 && b_ov && b_ordy) chk("b_out_data", 32'(b_od), 32'(qb.pop_front()));
      if (qc.size() != 0 && c_ov && c_ordy) chk("c_out_data", 32'(c_od), 32'(qc.pop_front()));
      b_acc = b_iv && b_ir;
      c_acc = c_iv && c_ir;
      if (b_flush) qb.delete(); else if (b_acc) qb.push_back(b_id);
      if (c_flush) qc.delete(); else if (c_acc) qc.push_back(c_id);
    end
    chk("b_drained", 32'(qb.size()), 0);
    chk("c_drained", 32'(qc.size()), 0);

    // RST_DATA=0: reset clears valid but keeps the data register
    @(negedge clk);
    c_iv = 1; c_id = 26'h1234567; c_ordy = 0;
    @(negedge clk);
    c_iv = 0;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (c_ov) break;
      @(negedge clk);
    end
    chk("c_word_reached_out", 32'(c_ov), 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("c_rst_out_valid", 32'(c_ov), 0);
    chk("c_rst_data_held", 32'(c_od), 32'h1234567);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
